// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate/commit, out-of-order writeback,
// wrap-bit head/tail pointers and a single-cycle squash when a mispredicted branch commits.
module rob_param #(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH),
    parameter int RD_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_alloc_valid,
    output logic             o_alloc_ready,
    input  logic [RD_W-1:0]  i_alloc_rd,
    input  logic             i_alloc_writes_rd,
    input  logic             i_alloc_is_branch,
    input  logic             i_alloc_is_store,
    output logic [TAG_W-1:0] o_alloc_tag,
    input  logic             i_wb_valid,
    input  logic [TAG_W-1:0] i_wb_tag,
    input  logic             i_wb_mispredict,
    output logic             o_commit_valid,
    input  logic             i_commit_ready,
    output logic [TAG_W-1:0] o_commit_tag,
    output logic [RD_W-1:0]  o_commit_rd,
    output logic             o_commit_regfile_load,
    output logic             o_commit_is_store,
    output logic             o_commit_mispredict,
    output logic             o_flush,
    output logic [TAG_W:0]   o_count,
    output logic             o_full,
    output logic             o_empty,
    output logic [DEPTH-1:0] o_valid_vec,
    output logic [DEPTH-1:0] o_alloc_vec
);

    localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

    logic [TAG_W:0]   r_head;
    logic [TAG_W:0]   r_tail;
    logic [DEPTH-1:0] r_alloc;
    logic [DEPTH-1:0] r_done;
    logic [DEPTH-1:0] r_mispred;
    logic [DEPTH-1:0] r_writes_rd;
    logic [DEPTH-1:0] r_is_branch;
    logic [DEPTH-1:0] r_is_store;
    logic [RD_W-1:0]  r_rd [DEPTH];

    logic [TAG_W-1:0] w_head_idx;
    logic [TAG_W-1:0] w_tail_idx;
    logic             w_full;
    logic             w_alloc_fire;
    logic             w_commit_fire;
    logic             w_flush;
    logic             w_wb_hit;
    logic [DEPTH-1:0] w_alloc_sel;
    logic [DEPTH-1:0] w_commit_sel;
    logic [DEPTH-1:0] w_wb_sel;

    assign w_head_idx = r_head[TAG_W-1:0];
    assign w_tail_idx = r_tail[TAG_W-1:0];

    // Same slot with opposite lap bits means the tail has lapped the head.
    assign w_full  = (r_head[TAG_W] != r_tail[TAG_W]) && (w_head_idx == w_tail_idx);
    assign o_full  = w_full;
    assign o_empty = (r_head == r_tail);
    assign o_count = r_tail - r_head;

    assign o_commit_valid        = r_alloc[w_head_idx] & r_done[w_head_idx];
    assign o_commit_tag          = w_head_idx;
    assign o_commit_rd           = r_rd[w_head_idx];
    assign o_commit_regfile_load = o_commit_valid & r_writes_rd[w_head_idx]
                                   & (r_rd[w_head_idx] != '0);
    assign o_commit_is_store     = r_alloc[w_head_idx] & r_is_store[w_head_idx];
    assign o_commit_mispredict   = r_alloc[w_head_idx] & r_is_branch[w_head_idx]
                                   & r_mispred[w_head_idx];

    assign w_commit_fire = o_commit_valid & i_commit_ready;
    assign w_flush       = w_commit_fire & o_commit_mispredict;
    assign o_flush       = w_flush;

    assign o_alloc_ready = ~w_full & ~w_flush;
    assign o_alloc_tag   = w_tail_idx;
    assign w_alloc_fire  = i_alloc_valid & o_alloc_ready;
    assign w_wb_hit      = i_wb_valid & r_alloc[i_wb_tag] & ~w_flush;

    assign o_valid_vec = r_done;
    assign o_alloc_vec = r_alloc;

    // One-hot entry selects for the three ports that touch per-entry state.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
        assign w_alloc_sel[gi]  = w_alloc_fire  && (w_tail_idx == TAG_W'(gi));
        assign w_commit_sel[gi] = w_commit_fire && (w_head_idx == TAG_W'(gi));
        assign w_wb_sel[gi]     = w_wb_hit      && (i_wb_tag   == TAG_W'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (w_flush) begin
            r_head <= r_head + PTR_ONE;
            r_tail <= r_head + PTR_ONE;
        end else begin
            if (w_alloc_fire)  r_tail <= r_tail + PTR_ONE;
            if (w_commit_fire) r_head <= r_head + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alloc     <= '0;
            r_done      <= '0;
            r_mispred   <= '0;
            r_writes_rd <= '0;
            r_is_branch <= '0;
            r_is_store  <= '0;
            for (int i = 0; i < DEPTH; i++) r_rd[i] <= '0;
        end else if (w_flush) begin
            r_alloc   <= '0;
            r_done    <= '0;
            r_mispred <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                // Later assignments win: a writeback racing the commit of its own entry is dropped.
                if (w_wb_sel[i]) begin
                    r_done[i]    <= 1'b1;
                    r_mispred[i] <= i_wb_mispredict & r_is_branch[i];
                end
                if (w_commit_sel[i]) begin
                    r_alloc[i] <= 1'b0;
                    r_done[i]  <= 1'b0;
                end
                if (w_alloc_sel[i]) begin
                    r_alloc[i]     <= 1'b1;
                    r_done[i]      <= 1'b0;
                    r_mispred[i]   <= 1'b0;
                    r_rd[i]        <= i_alloc_rd;
                    r_writes_rd[i] <= i_alloc_writes_rd;
                    r_is_branch[i] <= i_alloc_is_branch;
                    r_is_store[i]  <= i_alloc_is_store;
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_param.sv
// Bench for rob_param: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of in-flight instructions in program order.
module tb_rob_param;

    localparam int DEPTH = 8;
    localparam int TAG_W = 3;
    localparam int RD_W  = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             alloc_valid = 1'b0;
    logic             alloc_ready;
    logic [RD_W-1:0]  alloc_rd = '0;
    logic             alloc_writes_rd = 1'b0;
    logic             alloc_is_branch = 1'b0;
    logic             alloc_is_store = 1'b0;
    logic [TAG_W-1:0] alloc_tag;
    logic             wb_valid = 1'b0;
    logic [TAG_W-1:0] wb_tag = '0;
    logic             wb_mispredict = 1'b0;
    logic             commit_valid;
    logic             commit_ready = 1'b0;
    logic [TAG_W-1:0] commit_tag;
    logic [RD_W-1:0]  commit_rd;
    logic             commit_regfile_load;
    logic             commit_is_store;
    logic             commit_mispredict;
    logic             flush;
    logic [TAG_W:0]   count;
    logic             full;
    logic             empty;
    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] alloc_vec;

    rob_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .RD_W(RD_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_alloc_valid(alloc_valid), .o_alloc_ready(alloc_ready),
        .i_alloc_rd(alloc_rd), .i_alloc_writes_rd(alloc_writes_rd),
        .i_alloc_is_branch(alloc_is_branch), .i_alloc_is_store(alloc_is_store),
        .o_alloc_tag(alloc_tag),
        .i_wb_valid(wb_valid), .i_wb_tag(wb_tag), .i_wb_mispredict(wb_mispredict),
        .o_commit_valid(commit_valid), .i_commit_ready(commit_ready),
        .o_commit_tag(commit_tag), .o_commit_rd(commit_rd),
        .o_commit_regfile_load(commit_regfile_load),
        .o_commit_is_store(commit_is_store), .o_commit_mispredict(commit_mispredict),
        .o_flush(flush), .o_count(count), .o_full(full), .o_empty(empty),
        .o_valid_vec(valid_vec), .o_alloc_vec(alloc_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        logic [4:0] rd;
        bit         wr;
        bit         br;
        bit         st;
        bit         done;
        bit         mp;
    } ent_t;

    ent_t mq[$];
    int   m_head = 0;
    int   m_tail = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor/scoreboard: compares at the falling edge, then advances the model
    // to the state the coming rising edge should produce.
    always @(negedge clk) begin
        bit               e_cv, e_fire, e_flush, e_full, e_ar;
        logic [DEPTH-1:0] e_vv, e_av;
        ent_t             h, ne;
        if (!rst_n) begin
            mq.delete();
            m_head = 0;
            m_tail = 0;
            chk("rst_count", count, 0);
            chk("rst_empty", empty, 1);
            chk("rst_full", full, 0);
            chk("rst_commit_valid", commit_valid, 0);
            chk("rst_alloc_ready", alloc_ready, 1);
            chk("rst_alloc_tag", alloc_tag, 0);
            chk("rst_flush", flush, 0);
            chk("rst_commit_rd", commit_rd, 0);
            chk("rst_vecs", {valid_vec, alloc_vec}, 0);
        end else begin
            e_cv    = (mq.size() > 0) && mq[0].done;
            e_fire  = e_cv && commit_ready;
            e_flush = e_fire && mq[0].mp;
            e_full  = (mq.size() == DEPTH);
            e_ar    = !e_full && !e_flush;
            e_vv = '0;
            e_av = '0;
            foreach (mq[k]) begin
                e_av[mq[k].tag] = 1'b1;
                if (mq[k].done) e_vv[mq[k].tag] = 1'b1;
            end
            chk("count", count, mq.size());
            chk("full", full, e_full);
            chk("empty", empty, mq.size() == 0);
            chk("alloc_ready", alloc_ready, e_ar);
            chk("alloc_tag", alloc_tag, m_tail % DEPTH);
            chk("commit_valid", commit_valid, e_cv);
            chk("commit_tag", commit_tag, m_head % DEPTH);
            chk("flush", flush, e_flush);
            chk("valid_vec", valid_vec, e_vv);
            chk("alloc_vec", alloc_vec, e_av);
            if (e_cv) begin
                h = mq[0];
                chk("commit_rd", commit_rd, h.rd);
                chk("commit_regfile_load", commit_regfile_load, h.wr && (h.rd != 0));
                chk("commit_is_store", commit_is_store, h.st);
                chk("commit_mispredict", commit_mispredict, h.mp);
            end else begin
                chk("commit_regfile_load_idle", commit_regfile_load, 0);
            end
            if (e_fire) begin
                $display("[TB] commit tag=%0d rd=%0d load=%0d store=%0d flush=%0d",
                         mq[0].tag, mq[0].rd, mq[0].wr && (mq[0].rd != 0), mq[0].st, e_flush);
                void'(mq.pop_front());
                m_head++;
            end
            if (e_flush) begin
                mq.delete();
                m_tail = m_head;
            end else begin
                if (wb_valid) begin
                    foreach (mq[k]) begin
                        if (mq[k].tag == int'(wb_tag)) begin
                            mq[k].done = 1'b1;
                            mq[k].mp   = wb_mispredict && mq[k].br;
                        end
                    end
                end
                if (alloc_valid && e_ar) begin
                    ne.tag  = m_tail % DEPTH;
                    ne.rd   = alloc_rd;
                    ne.wr   = alloc_writes_rd;
                    ne.br   = alloc_is_branch;
                    ne.st   = alloc_is_store;
                    ne.done = 1'b0;
                    ne.mp   = 1'b0;
                    mq.push_back(ne);
                    m_tail++;
                end
            end
        end
    end

    task automatic drive(input bit av, input int rd, input bit wr, input bit br, input bit st,
                         input bit wv, input int wt, input bit wm, input bit cr);
        alloc_valid     = av;
        alloc_rd        = RD_W'(rd);
        alloc_writes_rd = wr;
        alloc_is_branch = br;
        alloc_is_store  = st;
        wb_valid        = wv;
        wb_tag          = TAG_W'(wt);
        wb_mispredict   = wm;
        commit_ready    = cr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit cr);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, cr);
    endtask

    initial begin
        int t0;
        int wb_order[8] = '{2, 1, 3, 0, 5, 4, 7, 6};
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2, 1);

        // Fill to DEPTH with no completions, then one refused allocation.
        for (int i = 0; i < DEPTH + 1; i++) drive(1, i + 1, 1, 0, 0, 0, 0, 0, 0);
        // Out-of-order completion, in-order retirement.
        for (int i = 0; i < DEPTH; i++) drive(0, 0, 0, 0, 0, 1, wb_order[i], 0, 1);
        idle(DEPTH + 2, 1);

        // Store held at head while the consumer stalls.
        t0 = int'(alloc_tag);
        drive(1, 3, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, t0, 0, 0);
        idle(3, 0);
        idle(2, 1);

        // ADD r5, BR (mispredicted), ADD r6, ST: squash at branch commit.
        t0 = int'(alloc_tag);
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
        drive(1, 6, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 9, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, 0, 1, (t0 + k) % DEPTH, k == 1, 0);
        idle(4, 1);

        // rd=0 write is not a regfile load; stray writeback to a free slot.
        t0 = int'(alloc_tag);
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, (t0 + 3) % DEPTH, 0, 0);
        drive(0, 0, 0, 0, 0, 1, t0, 0, 0);
        idle(3, 1);

        // Asynchronous reset with five entries in flight.
        for (int i = 0; i < 5; i++) drive(1, i + 10, 1, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2, 1);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            int r;
            bit br, st;
            r  = int'($urandom_range(0, 99));
            br = (r < 25);
            st = (r >= 25) && (r < 40);
            drive($urandom_range(0, 99) < 60, int'($urandom_range(0, 31)),
                  !br && !st && ($urandom_range(0, 3) != 0), br, st,
                  $urandom_range(0, 99) < 65, int'($urandom_range(0, DEPTH - 1)),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 99) < 70);
        end
        for (int c = 0; c < 40; c++)
            drive(0, 0, 0, 0, 0, 1, int'($urandom_range(0, DEPTH - 1)), 0, 1);
        idle(2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_param.md
Name: rob_param

Overview:
- Parametrised reorder buffer that succeeds the fixed 8-entry ROB in the Tomasulo out-of-order core. It sits between the instruction queue (allocation), the reservation stations/CDB (writeback), and the regfile/d-cache (in-order commit).
- Generalises depth and adds a wrap-bit pointer scheme, an occupancy count, and commit back-pressure.
- Mispredict recovery is a single-cycle squash taken at branch commit, replacing the multi-cycle walking flush and the external branch FIFO.

Parameters:
DEPTH, 8, number of entries; power of 2, at least 2.
TAG_W, $clog2(DEPTH), entry index width.
RD_W, 5, architectural register index width.

Ports:
clk  in  1  clock
rst_n  in  1  reset
alloc_valid  in  1  IQ has an instruction to allocate
alloc_ready  out  1  ROB can accept an allocation this cycle
alloc_rd  in  RD_W  destination register (store: data source register)
alloc_writes_rd  in  1  instruction writes the regfile
alloc_is_branch  in  1  instruction is a conditional branch
alloc_is_store  in  1  instruction is a store
alloc_tag  out  TAG_W  tag assigned to the current allocation (tail index)
wb_valid  in  1  CDB/RS reports a completed entry
wb_tag  in  TAG_W  completed entry
wb_mispredict  in  1  for branches: resolved direction differs from prediction
commit_valid  out  1  head entry is complete and presented for commit
commit_ready  in  1  consumer accepts the commit (store waits on data_mem_resp)
commit_tag  out  TAG_W  head index
commit_rd  out  RD_W  head rd/store source register
commit_regfile_load  out  1  commit_valid & head writes_rd & head rd != 0
commit_is_store  out  1  head is a store
commit_mispredict  out  1  head is a branch with its mispredict flag set
flush  out  1  squash pulse; all younger entries are discarded at this edge
count  out  TAG_W+1  occupied entries
full  out  1  count == DEPTH
empty  out  1  count == 0
valid_vec  out  DEPTH  per-entry done bits, for RS status
alloc_vec  out  DEPTH  per-entry allocated bits

Behaviour:
- Reset: one clock; asynchronous active-low reset named rst_n. Reset clears the head and tail pointers (TAG_W+1 bits each), all allocated/done/mispredict bits, and entry payloads.
  - After reset, all outputs are 0 except empty=1 and alloc_ready=1.
  - Reset mid-operation discards everything immediately.
- Pointers: tag = ptr[TAG_W-1:0]; wrap is modulo 2*DEPTH with the MSB as lap bit.
  - full: low bits equal and MSBs differ. empty: pointers equal.
  - count = tail - head (TAG_W+1-bit unsigned).
- Allocate:
  - alloc_ready = ~full & ~flush.
  - On alloc_valid & alloc_ready, at the edge: write the payload at tail, set allocated=1, clear done and mispredict bits, tail += 1.
  - alloc_tag = tail[TAG_W-1:0] combinationally.
  - alloc_ready uses registered full, so no allocation is accepted while full, even if a commit fires in the same cycle.
- Writeback:
  - On wb_valid with allocated[wb_tag]=1, set done and latch wb_mispredict (the latch is ANDed with is_branch).
  - Writeback to an unallocated tag is ignored.
  - A writeback to the head becomes visible for commit the next cycle (no bypass).
- Commit:
  - commit_valid = allocated[head] & done[head]. All commit_* fields come combinationally from the head entry.
  - Commit fires on commit_valid & commit_ready: clear allocated/done at head, head += 1. One commit per cycle.
  - commit_valid holds with stable fields until commit_ready is asserted.
- Flush:
  - flush = commit fire & commit_mispredict (combinational).
  - At that edge: clear all allocated/done/mispredict bits, head <= head+1, tail <= head+1, count becomes 0.
  - Allocations and writebacks in the flush cycle are dropped.
  - Latency is one cycle: alloc_ready returns the next cycle.
- Simultaneous allocate and commit (not full, no flush): both occur; count is unchanged.
- Allocate into the entry being committed cannot happen, because that would require full.

Test Plan:
- Reset with rst_n=0 asserted mid-stream (count=5) -> within the same cycle count=0, empty=1, commit_valid=0; after release, alloc_tag=0.
- DEPTH=8: allocate 8 with no commit -> full=1, alloc_ready=0, count=8. The 9th alloc_valid is not accepted and tail is unchanged.
- DEPTH=4: allocate tags 0-3, writeback 2,1,3,0 out of order, commit_ready=1 -> commits in order 0,1,2,3 on consecutive cycles starting the cycle after wb of tag 0. Then 10 further alloc/wb/commit pairs verify wrap: tags cycle 0-3, and count never exceeds 4.
- Head is a store, commit_ready=0 for 3 cycles -> commit_valid=1 and commit_is_store=1 held stable with head unchanged; on the 4th cycle, commit_ready=1 fires the commit.
- Allocate ADD(rd=5), BR, ADD(rd=6), ST. Writeback all, BR with wb_mispredict=1 -> ADD commits with regfile_load=1, rd=5. Next cycle the BR commit pulses flush=1. The following cycle shows count=0, empty=1, and the next alloc_tag = BR tag+1. rd=6 and the store never commit.
- Allocate with rd=0 and writes_rd=1, then commit -> commit_valid=1, commit_regfile_load=0. A writeback to an unallocated tag leaves valid_vec unchanged.
